// File: rtl/update_writer.sv
`default_nettype none
// ============================================================================
// Module   : update_writer
// Brief    : Write-back stage behind the PE combining network. Buffers packed
//            update words in a 16-entry FIFO, drains them to the memory write
//            channel with ready/valid and sequential line addresses, raises
//            stall_request towards the PE when nearly full, and reports
//            partition flush completion.
// Options  : UPDATE_WRITER_WRAP_EN - ring-buffer addressing over region_lines.
// Revision : 1.0 - initial release
// ============================================================================
module update_writer #(
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DEPTH_W    = 4,
  parameter int unsigned AF_TH      = 12,
  parameter int unsigned LINE_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst,            // asynchronous, active-low
  input  logic              par_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       region_lines,
  input  logic              flush,
  input  logic [DATA_W-1:0] upd_word,
  input  logic              upd_valid,
  output logic              stall_request,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [31:0]       lines_written,
  output logic              flush_done,
  output logic              overflow
);

  localparam int unsigned       c_DEPTH    = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0]  c_FULL     = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [DEPTH_W:0]  c_AF_TH    = AF_TH[DEPTH_W:0];
  localparam logic [ADDR_W-1:0] c_LINE_INC = ADDR_W'(LINE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [DATA_W-1:0]   r_mem [c_DEPTH];
  logic [DEPTH_W-1:0]  r_wptr;
  logic [DEPTH_W-1:0]  r_rptr;
  logic [DEPTH_W:0]    r_count;
  logic [ADDR_W-1:0]   r_addr_next;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_addr_cur;
  logic [ADDR_W-1:0]   w_addr_after;

  assign w_full   = (r_count == c_FULL);
  assign w_empty  = (r_count == '0);
  // Head moves to the output register whenever that register is free or
  // is being accepted by memory this cycle.
  assign w_pop    = !w_empty && (!wr_valid || wr_ready);
  // A pop frees a slot in the same cycle, so a full FIFO still takes a word.
  assign w_push   = upd_valid && (!w_full || w_pop);
  assign w_accept = wr_valid && wr_ready;

  // A par_start in the same cycle as a pop makes that line the first of the
  // new partition.
  assign w_addr_cur = par_start ? base_addr : r_addr_next;

`ifdef UPDATE_WRITER_WRAP_EN
  logic [ADDR_W-1:0]   r_base;
  logic [31:0]         r_region;
  logic [31:0]         r_load_cnt;
  logic [ADDR_W-1:0]   w_base_cur;
  logic [31:0]         w_region_cur;
  logic [31:0]         w_cnt_cur;
  logic                w_wrap;
  logic [31:0]         w_cnt_after;

  assign w_base_cur   = par_start ? base_addr : r_base;
  assign w_region_cur = par_start ? region_lines : r_region;
  assign w_cnt_cur    = par_start ? 32'd0 : r_load_cnt;
  // A zero-sized region means linear addressing.
  assign w_wrap       = (w_region_cur != 32'd0) && ((w_cnt_cur + 32'd1) >= w_region_cur);
  assign w_addr_after = w_wrap ? w_base_cur : (w_addr_cur + c_LINE_INC);
  assign w_cnt_after  = w_wrap ? 32'd0 : (w_cnt_cur + 32'd1);

  // Ring-region bookkeeping: partition base, size and lines issued so far.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base     <= '0;
      r_region   <= '0;
      r_load_cnt <= '0;
    end else begin
      if (par_start) begin
        r_base   <= base_addr;
        r_region <= region_lines;
      end
      if (w_pop)
        r_load_cnt <= w_cnt_after;
      else if (par_start)
        r_load_cnt <= '0;
    end
  end
`else
  logic w_unused_region;
  assign w_unused_region = ^region_lines;
  assign w_addr_after    = w_addr_cur + c_LINE_INC;
`endif

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= upd_word;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{DEPTH_W{1'b0}}, w_push} - {{DEPTH_W{1'b0}}, w_pop};
    end
  end

  // Output request register; held stable while memory withholds ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (w_pop) begin
      wr_valid <= 1'b1;
      wr_addr  <= w_addr_cur;
      wr_data  <= r_mem[r_rptr];
    end else if (w_accept) begin
      wr_valid <= 1'b0;
    end
  end

  // Next line address, accepted-line counter, sticky overflow, stall flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr_next   <= '0;
      lines_written <= '0;
      overflow      <= 1'b0;
      stall_request <= 1'b0;
    end else begin
      if (w_pop)
        r_addr_next <= w_addr_after;
      else if (par_start)
        r_addr_next <= base_addr;
      if (par_start)
        lines_written <= '0;
      else if (w_accept)
        lines_written <= lines_written + 32'd1;
      if (upd_valid && !w_push)
        overflow <= 1'b1;
      stall_request <= (r_count >= c_AF_TH);
    end
  end

  // Partition state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  // Partition sequencing and flush completion pulse.
  always_comb begin
    w_state_next = r_state;
    flush_done   = 1'b0;
    case (r_state)
      ST_IDLE: ;
      ST_RUN: begin
        if (flush)
          w_state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_empty && !wr_valid && !upd_valid && !par_start) begin
          flush_done   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (par_start)
      w_state_next = ST_RUN;
  end

endmodule
`default_nettype wire
